// File: rtl/n_core_pkg.sv
// Shared definitions for the n_core input path: event-word type codes and field layout.
package n_core_pkg;

    typedef enum logic [1:0] {
        EV_SPIKE = 2'b00,
        EV_EOT   = 2'b01,
        EV_EOS   = 2'b10,
        EV_RSVD  = 2'b11
    } ev_type_e;

    // Event word = {type, id}; the id occupies the low SPIKE_WIDTH bits.
    localparam int EV_TYPE_WIDTH = 2;
    localparam int EV_ID_LSB     = 0;

endpackage

// File: rtl/spike_injector.sv
// Walks a spike-event list in a sync-read RAM and pushes spike IDs into n_core's input queue,
// one timestep at a time. Define SPIKE_INJECTOR_LOOP_EN to replay the stream forever.
module spike_injector
    import n_core_pkg::*;
#(
    parameter int SPIKE_WIDTH   = 4,
    parameter int EV_ADDR_WIDTH = 10,
    parameter int STEP_WIDTH    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    output logic [EV_ADDR_WIDTH-1:0] ev_adr_o,
    input  logic [SPIKE_WIDTH+1:0]   ev_dat_i,
    input  logic                     full_i,
    output logic                     wr_o,
    output logic [SPIKE_WIDTH-1:0]   wr_data_o,
    input  logic                     tick_i,
    output logic [STEP_WIDTH-1:0]    step_cnt_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_PUSH,
        S_WAIT_TICK,
        S_DONE
    } state_e;

    localparam logic [EV_ADDR_WIDTH-1:0] ADR_ONE  = 1;
    localparam logic [STEP_WIDTH-1:0]    STEP_ONE = 1;

    state_e                   state_q, state_d;
    logic [EV_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [STEP_WIDTH-1:0]    step_q, step_d;
    logic [SPIKE_WIDTH-1:0]   id_q, id_d;
    logic                     wr;
    ev_type_e                 ev_type;

    assign ev_type = ev_type_e'(ev_dat_i[SPIKE_WIDTH +: EV_TYPE_WIDTH]);

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        step_d  = step_q;
        id_d    = id_q;
        wr      = 1'b0;

        case (state_q)
            S_IDLE: begin
                adr_d  = '0;
                step_d = '0;
                if (en_i) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (ev_type)
                    EV_SPIKE: begin
                        id_d    = ev_dat_i[EV_ID_LSB +: SPIKE_WIDTH];
                        state_d = S_PUSH;
                    end
                    EV_EOT: begin
                        adr_d   = adr_q + ADR_ONE;
                        state_d = S_WAIT_TICK;
                    end
                    default: begin
`ifdef SPIKE_INJECTOR_LOOP_EN
                        adr_d   = '0;
                        state_d = S_WAIT_TICK;
`else
                        state_d = S_DONE;
`endif
                    end
                endcase
            end
            S_PUSH: begin
                // The push completes on the edge where wr is high; a full queue simply stalls here.
                if (!full_i) begin
                    wr      = 1'b1;
                    adr_d   = adr_q + ADR_ONE;
                    state_d = S_FETCH;
                end
            end
            S_WAIT_TICK: begin
                if (tick_i) begin
                    step_d  = step_q + STEP_ONE;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Dropping the enable aborts everything, including a push that would otherwise issue.
        if (!en_i) begin
            state_d = S_IDLE;
            adr_d   = '0;
            step_d  = '0;
            wr      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            step_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            step_q  <= step_d;
            id_q    <= id_d;
        end
    end

    assign ev_adr_o   = adr_q;
    assign step_cnt_o = step_q;
    assign wr_o       = wr;
    assign wr_data_o  = (state_q == S_PUSH) ? id_q : '0;
    assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
`ifdef SPIKE_INJECTOR_LOOP_EN
    assign done_o     = 1'b0;
`else
    assign done_o     = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_spike_injector.sv
// Scoreboard bench for spike_injector: a list-walking model predicts pushed IDs and step counts.
module tb_spike_injector;
    import n_core_pkg::*;

    localparam int SW = 4;
    localparam int AW = 10;
    localparam int TW = 16;

    logic          clk    = 1'b0;
    logic          rst_i  = 1'b1;
    logic          en_i   = 1'b0;
    logic          full_i = 1'b0;
    logic          tick_i = 1'b0;
    logic [AW-1:0] ev_adr;
    logic [SW+1:0] ev_dat;
    logic          wr;
    logic [SW-1:0] wr_data;
    logic [TW-1:0] step_cnt;
    logic          busy;
    logic          done;

    spike_injector #(.SPIKE_WIDTH(SW), .EV_ADDR_WIDTH(AW), .STEP_WIDTH(TW)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .ev_adr_o(ev_adr), .ev_dat_i(ev_dat),
        .full_i(full_i), .wr_o(wr), .wr_data_o(wr_data), .tick_i(tick_i),
        .step_cnt_o(step_cnt), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    logic [SW+1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) ev_dat <= ram[ev_adr];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cycle    = 0;
    int            exp_q[$];
    int            push_times[$];
    int            exp_eot;
    bit            rand_mode = 1'b0;
    logic [SW+1:0] prog[$];

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [SW+1:0] ev(input ev_type_e t, input int id);
        return {t, id[SW-1:0]};
    endfunction

    // Monitor: a push is committed on the edge following a negedge with wr high.
    always @(negedge clk) begin
        if (rst_i && wr) begin
            check("push_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("push_id", wr_data, exp_q.pop_front());
            push_times.push_back(cycle);
        end
    end

    // Random back-pressure and tick traffic.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_mode) begin
            full_i = ($urandom_range(0, 3) == 0);
            tick_i = ($urandom_range(0, 7) == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: the stream is the list up to its first EOS/reserved word.
    task automatic model_stream();
        exp_eot = 0;
        for (int i = 0; i < prog.size(); i++) begin
            if (prog[i][SW+1:SW] == 2'b00) exp_q.push_back(int'(prog[i][SW-1:0]));
            else if (prog[i][SW+1:SW] == 2'b01) exp_eot++;
            else break;
        end
    endtask

    task automatic restart();
        en_i   = 1'b0;
        full_i = 1'b0;
        tick_i = 1'b0;
        step(1);
        exp_q.delete();
        push_times.delete();
        for (int i = 0; i < (1 << AW); i++) ram[i] = ev(EV_EOS, 0);
        for (int i = 0; i < prog.size(); i++) ram[i] = prog[i];
        model_stream();
        en_i = 1'b1;
    endtask

    task automatic pulse_tick();
        tick_i = 1'b1;
        step(1);
        tick_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            step(1);
            k++;
        end
        check("done_reached", done, 1);
    endtask

    initial begin
        #1 rst_i = 1'b0;
        #2;
        check("rst_wr", wr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_adr", ev_adr, 0);
        check("rst_step", step_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        step(2);
        rst_i = 1'b1;

`ifdef SPIKE_INJECTOR_LOOP_EN
        // Looping stream: one pass before the first tick, then one more after each tick.
        prog = '{ev(EV_SPIKE, 2), ev(EV_EOS, 0)};
        restart();
        repeat (3) exp_q.push_back(2);
        repeat (3) begin
            step(15);
            pulse_tick();
        end
        step(15);
        check("loop_pushes", push_times.size(), 4);
        check("loop_done", done, 0);
        check("loop_queue_empty", exp_q.size(), 0);
        check("loop_step", step_cnt, 3);
`else
        // Two timesteps; EOS does not close a timestep, so a tick in DONE is ignored.
        prog = '{ev(EV_SPIKE, 3), ev(EV_SPIKE, 7), ev(EV_EOT, 0), ev(EV_SPIKE, 1), ev(EV_EOS, 0)};
        restart();
        step(25);
        check("t1_pushes_before_tick", push_times.size(), 2);
        check("t1_step_before_tick", step_cnt, 0);
        check("t1_busy_waiting", busy, 1);
        if (push_times.size() >= 2) check("t1_spacing", push_times[1] - push_times[0], 3);
        pulse_tick();
        step(1);
        check("t1_step_after_tick", step_cnt, 1);
        wait_done(50);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_pushes_total", push_times.size(), 3);
        pulse_tick();
        step(3);
        check("t1_step_final", step_cnt, 1);
        check("t1_done_held", done, 1);
        check("t1_busy_done", busy, 0);

        // Back-pressure on ID 9.
        prog = '{ev(EV_SPIKE, 9), ev(EV_EOS, 0)};
        restart();
        full_i = 1'b1;
        step(3);
        repeat (5) begin
            @(negedge clk);
            check("t2_wr_while_full", wr, 0);
            check("t2_data_held", wr_data, 9);
        end
        @(posedge clk);
        #1 full_i = 1'b0;
        wait_done(20);
        check("t2_single_push", push_times.size(), 1);
        check("t2_queue_empty", exp_q.size(), 0);

        // Empty timesteps.
        prog = '{ev(EV_EOT, 0), ev(EV_EOT, 0), ev(EV_EOT, 0), ev(EV_EOS, 0)};
        restart();
        repeat (3) begin
            step(10);
            check("t3_busy_waiting", busy, 1);
            pulse_tick();
        end
        wait_done(30);
        check("t3_step", step_cnt, 3);
        check("t3_no_push", push_times.size(), 0);

        // Disable during a push, then replay from address 0.
        prog = '{ev(EV_EOT, 0), ev(EV_SPIKE, 5), ev(EV_SPIKE, 6), ev(EV_EOS, 0)};
        restart();
        full_i = 1'b1;
        step(6);
        pulse_tick();
        step(4);
        @(negedge clk);
        check("t4_in_push_id", wr_data, 5);
        check("t4_step_before", step_cnt, 1);
        @(posedge clk);
        #1;
        full_i = 1'b0;
        en_i   = 1'b0;
        #1 check("t4_wr_suppressed", wr, 0);
        step(1);
        check("t4_idle_adr", ev_adr, 0);
        check("t4_idle_step", step_cnt, 0);
        check("t4_idle_busy", busy, 0);
        exp_q.delete();
        push_times.delete();
        model_stream();
        en_i = 1'b1;
        step(8);
        pulse_tick();
        wait_done(30);
        check("t4_replay_pushes", push_times.size(), 2);
        check("t4_replay_step", step_cnt, 1);

        // Ticks outside WAIT_TICK are ignored.
        prog = '{ev(EV_SPIKE, 4), ev(EV_EOT, 0), ev(EV_EOS, 0)};
        restart();
        full_i = 1'b1;
        step(1);
        tick_i = 1'b1;
        step(1);
        tick_i = 1'b0;
        step(2);
        pulse_tick();
        check("t5_step_after_stray_ticks", step_cnt, 0);
        full_i = 1'b0;
        step(8);
        check("t5_step_waiting", step_cnt, 0);
        pulse_tick();
        wait_done(20);
        check("t5_step_final", step_cnt, 1);
        check("t5_pushes", push_times.size(), 1);

        // Asynchronous reset while a push is about to issue.
        prog = '{ev(EV_SPIKE, 8), ev(EV_EOS, 0)};
        restart();
        full_i = 1'b1;
        step(4);
        full_i = 1'b0;
        rst_i  = 1'b0;
        #1;
        check("t7_wr_async_drop", wr, 0);
        check("t7_adr_async", ev_adr, 0);
        en_i = 1'b0;
        step(1);
        rst_i = 1'b1;
        step(1);
        check("t7_no_push", push_times.size(), 0);

        // Randomized lists under random back-pressure and ticks.
        for (int it = 0; it < 10; it++) begin
            int len;
            prog.delete();
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) begin
                int r = $urandom_range(0, 9);
                if (r < 6) prog.push_back(ev(EV_SPIKE, $urandom_range(0, 15)));
                else prog.push_back(ev(EV_EOT, 0));
            end
            prog.push_back($urandom_range(0, 1) ? ev(EV_EOS, 0) : ev(EV_RSVD, $urandom_range(0, 15)));
            restart();
            rand_mode = 1'b1;
            wait_done(3000);
            rand_mode = 1'b0;
            full_i    = 1'b0;
            tick_i    = 1'b0;
            check("rand_step", step_cnt, exp_eot);
            check("rand_queue_empty", exp_q.size(), 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
